// File: rtl/dijkstra_params.sv
`default_nettype none
// ============================================================================
// dijkstra_params : shared constants and types for the dijkstra accelerator
// Revision: 1.0
// ============================================================================
package dijkstra_params;

    localparam int VIRTEX_DWIDTH    = 16;
    localparam int VIRTEX_NUM_WIDTH = 5;
    localparam int VIRTEX_AWIDTH    = 6;
    localparam int PIPE_WIDTH       = 4;
    localparam int PIPE_SHIFT       = 2;
    localparam int MAX_VIRTEX_NUM   = 16;
    localparam int LINES_PER_ROW    = MAX_VIRTEX_NUM / PIPE_WIDTH;

    localparam logic [VIRTEX_DWIDTH-1:0] NO_LINK = '1;

    typedef logic [PIPE_WIDTH-1:0][VIRTEX_DWIDTH-1:0] weight_line_t;

    localparam weight_line_t NO_LINK_LINE = {PIPE_WIDTH{NO_LINK}};

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_LOAD = 3'b010,
        ST_DONE = 3'b100
    } wmem_state_e;

endpackage
`default_nettype wire

// File: rtl/dijkstra_line_packer.sv
`default_nettype none
// ============================================================================
// dijkstra_line_packer : packs the row-major weight stream into padded lines
// Revision: 1.0
// ============================================================================
module dijkstra_line_packer
    import dijkstra_params::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_clear,
    input  logic                        i_accept,
    input  logic [VIRTEX_DWIDTH-1:0]    i_data,
    input  logic [VIRTEX_NUM_WIDTH-1:0] i_virt_num,
    output logic                        o_line_we,
    output logic [VIRTEX_AWIDTH-1:0]    o_line_addr,
    output weight_line_t                o_line_data,
    output logic                        o_last_word
);

    logic [PIPE_SHIFT-1:0]       r_lane_cnt;
    logic [VIRTEX_NUM_WIDTH-1:0] r_col_cnt;
    logic [VIRTEX_NUM_WIDTH-1:0] r_row_cnt;
    weight_line_t                r_lanes;

    logic [VIRTEX_NUM_WIDTH-1:0] w_n_m1;
    logic                        w_last_col;
    logic                        w_last_lane;

    assign w_n_m1      = i_virt_num - VIRTEX_NUM_WIDTH'(1);
    assign w_last_col  = (r_col_cnt == w_n_m1);
    assign w_last_lane = (r_lane_cnt == PIPE_SHIFT'(PIPE_WIDTH - 1));

    // Lanes below the cursor come from the register, the cursor lane from
    // the incoming word, and everything above it is padding.
    for (genvar i = 0; i < PIPE_WIDTH; i++) begin : g_lane
        assign o_line_data[i] = (PIPE_SHIFT'(i) <  r_lane_cnt) ? r_lanes[i] :
                                (PIPE_SHIFT'(i) == r_lane_cnt) ? i_data     :
                                                                 NO_LINK;
    end

    assign o_line_we   = i_accept & (w_last_lane | w_last_col);
    assign o_last_word = i_accept & w_last_col & (r_row_cnt == w_n_m1);
    assign o_line_addr = VIRTEX_AWIDTH'(32'(r_row_cnt) * 32'(LINES_PER_ROW)
                                        + 32'(r_col_cnt >> PIPE_SHIFT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lane_cnt <= '0;
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
            r_lanes    <= NO_LINK_LINE;
        end else if (i_clear) begin
            r_lane_cnt <= '0;
            r_col_cnt  <= '0;
            r_row_cnt  <= '0;
        end else if (i_accept) begin
            r_lanes[r_lane_cnt] <= i_data;
            if (w_last_col) begin
                r_col_cnt  <= '0;
                r_lane_cnt <= '0;
                r_row_cnt  <= r_row_cnt + VIRTEX_NUM_WIDTH'(1);
            end else begin
                r_col_cnt  <= r_col_cnt + VIRTEX_NUM_WIDTH'(1);
                r_lane_cnt <= r_lane_cnt + PIPE_SHIFT'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dijkstra_weights_mem.sv
`default_nettype none
// ============================================================================
// dijkstra_weights_mem : host-loaded adjacency weight store, one line per read
// Revision: 1.0
// ============================================================================
module dijkstra_weights_mem
    import dijkstra_params::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_start_i,
    input  logic [VIRTEX_NUM_WIDTH-1:0] load_virt_num_i,
    input  logic                        load_valid_i,
    input  logic [VIRTEX_DWIDTH-1:0]    load_data_i,
    output logic                        load_ready_o,
    output logic                        load_done_o,
    output logic                        load_err_o,
    input  logic                        weights_ram_cs_i,
    input  logic [VIRTEX_AWIDTH-1:0]    weights_ram_addr_i,
    output weight_line_t                weights_ram_data_o,
    output logic                        rd_conflict_o
);

    localparam int c_MEM_DEPTH = 1 << VIRTEX_AWIDTH;

    wmem_state_e                 r_state;
    logic [VIRTEX_NUM_WIDTH-1:0] r_virt_num;
    weight_line_t                r_mem [c_MEM_DEPTH];

    logic                        w_accept;
    logic                        w_n_ok;
    logic                        w_start;
    logic                        w_line_we;
    logic [VIRTEX_AWIDTH-1:0]    w_line_addr;
    weight_line_t                w_line_data;
    logic                        w_last_word;

    assign w_accept = load_valid_i & load_ready_o;
    assign w_n_ok   = (load_virt_num_i != '0) &&
                      (load_virt_num_i <= VIRTEX_NUM_WIDTH'(MAX_VIRTEX_NUM));
    assign w_start  = (r_state == ST_IDLE) & load_start_i & w_n_ok;

    dijkstra_line_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_start),
        .i_accept    (w_accept),
        .i_data      (load_data_i),
        .i_virt_num  (r_virt_num),
        .o_line_we   (w_line_we),
        .o_line_addr (w_line_addr),
        .o_line_data (w_line_data),
        .o_last_word (w_last_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_virt_num   <= '0;
            load_ready_o <= 1'b0;
            load_done_o  <= 1'b0;
            load_err_o   <= 1'b0;
        end else begin
            load_done_o <= 1'b0;
            load_err_o  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (load_start_i) begin
                        if (w_n_ok) begin
                            r_state      <= ST_LOAD;
                            r_virt_num   <= load_virt_num_i;
                            load_ready_o <= 1'b1;
                        end else begin
                            load_err_o <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_last_word) begin
                        r_state      <= ST_DONE;
                        load_ready_o <= 1'b0;
                        load_done_o  <= 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: begin
                    r_state      <= ST_IDLE;
                    load_ready_o <= 1'b0;
                end
            endcase
        end
    end

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_line_we) begin
            r_mem[w_line_addr] <= w_line_data;
        end
    end

    // A read colliding with loading (or with a line write) sees only padding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            weights_ram_data_o <= NO_LINK_LINE;
            rd_conflict_o      <= 1'b0;
        end else begin
            rd_conflict_o <= 1'b0;
            if (weights_ram_cs_i) begin
                if ((r_state == ST_LOAD) || w_line_we) begin
                    weights_ram_data_o <= NO_LINK_LINE;
                    rd_conflict_o      <= 1'b1;
                end else begin
                    weights_ram_data_o <= r_mem[weights_ram_addr_i];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dijkstra_weights_mem.sv
`default_nettype none
// ============================================================================
// tb_dijkstra_weights_mem : directed self-checking bench for the weight store
// Revision: 1.0
// ============================================================================
module tb_dijkstra_weights_mem;
    import dijkstra_params::*;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b1;
    logic                        load_start_i = 1'b0;
    logic [VIRTEX_NUM_WIDTH-1:0] load_virt_num_i = '0;
    logic                        load_valid_i = 1'b0;
    logic [VIRTEX_DWIDTH-1:0]    load_data_i = '0;
    logic                        load_ready_o;
    logic                        load_done_o;
    logic                        load_err_o;
    logic                        weights_ram_cs_i = 1'b0;
    logic [VIRTEX_AWIDTH-1:0]    weights_ram_addr_i = '0;
    weight_line_t                weights_ram_data_o;
    logic                        rd_conflict_o;

    int n_checks = 0;
    int n_errors = 0;

    dijkstra_weights_mem dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .load_start_i       (load_start_i),
        .load_virt_num_i    (load_virt_num_i),
        .load_valid_i       (load_valid_i),
        .load_data_i        (load_data_i),
        .load_ready_o       (load_ready_o),
        .load_done_o        (load_done_o),
        .load_err_o         (load_err_o),
        .weights_ram_cs_i   (weights_ram_cs_i),
        .weights_ram_addr_i (weights_ram_addr_i),
        .weights_ram_data_o (weights_ram_data_o),
        .rd_conflict_o      (rd_conflict_o)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk_line(input logic [15:0] l0, input logic [15:0] l1,
                                            input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic start_load(input logic [4:0] n);
        load_start_i    = 1'b1;
        load_virt_num_i = n;
        @(negedge clk);
        load_start_i    = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d);
        load_valid_i = 1'b1;
        load_data_i  = d;
        @(negedge clk);
        load_valid_i = 1'b0;
    endtask

    task automatic read_line(input string tag, input logic [5:0] addr, input logic [63:0] exp);
        weights_ram_cs_i   = 1'b1;
        weights_ram_addr_i = addr;
        @(negedge clk);
        weights_ram_cs_i   = 1'b0;
        check_value(tag, weights_ram_data_o, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_value("rst_ready", load_ready_o, 0);
        check_value("rst_done", load_done_o, 0);
        check_value("rst_err", load_err_o, 0);
        check_value("rst_conflict", rd_conflict_o, 0);
        check_value("rst_data", weights_ram_data_o, {64{1'b1}});
        rst_n = 1'b1;
        @(negedge clk);

        // n=4 back-to-back load, read in the DONE cycle
        start_load(5'd4);
        check_value("n4_ready", load_ready_o, 1);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) check_value("n4_done_early", load_done_o, 0);
            send_word(16'(k + 1));
        end
        check_value("n4_done", load_done_o, 1);
        read_line("n4_addr12_done_cycle", 6'd12, mk_line(16'd13, 16'd14, 16'd15, 16'd16));
        check_value("n4_done_pulse_end", load_done_o, 0);
        check_value("n4_ready_after", load_ready_o, 0);
        read_line("n4_addr0", 6'd0, mk_line(16'd1, 16'd2, 16'd3, 16'd4));
        read_line("n4_addr4", 6'd4, mk_line(16'd5, 16'd6, 16'd7, 16'd8));
        read_line("hold_check_setup", 6'd8, mk_line(16'd9, 16'd10, 16'd11, 16'd12));
        @(negedge clk);
        check_value("data_hold", weights_ram_data_o, mk_line(16'd9, 16'd10, 16'd11, 16'd12));

        // n=16 full matrix
        start_load(5'd16);
        for (int k = 0; k < 256; k++) send_word(16'h1000 + 16'(k));
        check_value("n16_done", load_done_o, 1);
        @(negedge clk);
        read_line("n16_addr2", 6'd2, mk_line(16'h1008, 16'h1009, 16'h100A, 16'h100B));
        read_line("n16_addr63", 6'd63, mk_line(16'h10FC, 16'h10FD, 16'h10FE, 16'h10FF));

        // n=6 padding; untouched lines keep n=16 contents
        start_load(5'd6);
        for (int k = 0; k < 36; k++) send_word((k < 6) ? 16'(k + 1) : 16'h0200 + 16'(k));
        check_value("n6_done", load_done_o, 1);
        @(negedge clk);
        read_line("n6_addr0", 6'd0, mk_line(16'd1, 16'd2, 16'd3, 16'd4));
        read_line("n6_addr1_pad", 6'd1, mk_line(16'd5, 16'd6, 16'hFFFF, 16'hFFFF));
        read_line("n6_addr2_kept", 6'd2, mk_line(16'h1008, 16'h1009, 16'h100A, 16'h100B));
        read_line("n6_addr4_row1", 6'd4, mk_line(16'h0206, 16'h0207, 16'h0208, 16'h0209));
        read_line("n6_addr5_pad", 6'd5, mk_line(16'h020A, 16'h020B, 16'hFFFF, 16'hFFFF));
        read_line("n6_addr20_row5", 6'd20, mk_line(16'h021E, 16'h021F, 16'h0220, 16'h0221));
        read_line("n6_addr24_kept", 6'd24, mk_line(16'h1060, 16'h1061, 16'h1062, 16'h1063));

        // n=4 with valid pattern 1/0/0
        start_load(5'd4);
        for (int k = 0; k < 16; k++) begin
            send_word(16'h0030 + 16'(k));
            if (k != 15) begin
                @(negedge clk);
                @(negedge clk);
                if (k == 14) check_value("bp_done_early", load_done_o, 0);
            end
        end
        check_value("bp_done", load_done_o, 1);
        @(negedge clk);
        read_line("bp_addr0", 6'd0, mk_line(16'h30, 16'h31, 16'h32, 16'h33));
        read_line("bp_addr12", 6'd12, mk_line(16'h3C, 16'h3D, 16'h3E, 16'h3F));

        // read during load
        start_load(5'd4);
        send_word(16'h0050);
        send_word(16'h0051);
        read_line("rdl_data", 6'd0, {64{1'b1}});
        check_value("rdl_conflict", rd_conflict_o, 1);
        @(negedge clk);
        check_value("rdl_conflict_end", rd_conflict_o, 0);
        for (int k = 2; k < 16; k++) send_word(16'h0050 + 16'(k));
        check_value("rdl_done", load_done_o, 1);
        @(negedge clk);
        read_line("rdl_addr0", 6'd0, mk_line(16'h50, 16'h51, 16'h52, 16'h53));
        check_value("rdl_no_conflict_idle", rd_conflict_o, 0);
        read_line("rdl_addr4", 6'd4, mk_line(16'h54, 16'h55, 16'h56, 16'h57));

        // rejected starts
        start_load(5'd0);
        check_value("rej0_err", load_err_o, 1);
        check_value("rej0_ready", load_ready_o, 0);
        @(negedge clk);
        check_value("rej0_err_end", load_err_o, 0);
        start_load(5'd17);
        check_value("rej17_err", load_err_o, 1);
        check_value("rej17_ready", load_ready_o, 0);
        @(negedge clk);
        check_value("rej17_ready_later", load_ready_o, 0);
        read_line("rej_still_idle", 6'd0, mk_line(16'h50, 16'h51, 16'h52, 16'h53));
        check_value("rej_no_conflict", rd_conflict_o, 0);

        // reset in the middle of a load
        start_load(5'd4);
        for (int k = 0; k < 5; k++) send_word(16'(k + 1));
        #2 rst_n = 1'b0;
        #1 check_value("mid_rst_ready", load_ready_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read_line("mid_rst_addr0", 6'd0, mk_line(16'd1, 16'd2, 16'd3, 16'd4));
        start_load(5'd4);
        for (int k = 0; k < 16; k++) send_word(16'h0060 + 16'(k));
        check_value("post_rst_done", load_done_o, 1);
        @(negedge clk);
        read_line("post_rst_addr0", 6'd0, mk_line(16'h60, 16'h61, 16'h62, 16'h63));
        read_line("post_rst_addr4", 6'd4, mk_line(16'h64, 16'h65, 16'h66, 16'h67));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
